// File: rtl/pixel_stream_pkg.sv
// Shared constants and types for the pixel packing / streaming stages.
package pixel_stream_pkg;

  localparam int PIX_W          = 16;
  localparam int AXIS_W         = 64;
  localparam int PIX_PER_WORD   = 4;

  // Default frame geometry and buffering
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_BURST_LEN  = 16;
  localparam int DEF_FIFO_DEPTH = 512;

  // FIFO entry layout: {tlast, tuser, data}
  localparam int TAG_TUSER_BIT  = AXIS_W;
  localparam int TAG_TLAST_BIT  = AXIS_W + 1;
  localparam int FIFO_W         = AXIS_W + 2;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } pack_state_e;

  typedef struct packed {
    logic              tlast;
    logic              tuser;
    logic [AXIS_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered output stage. The output register counts
// toward capacity, so DEPTH words can be held in total. A write into an empty
// FIFO lands directly in the output register, giving one cycle write-to-valid.
// Simultaneous read and write are supported every cycle, including when full.
module sync_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;

  logic pop;
  logic wr_acc;
  logic load_out;
  logic mem_empty;
  logic mem_rd;
  logic mem_wr;
  logic bypass;

  // A pop in the same cycle frees a slot, so a write is still accepted when full
  assign pop       = rd_en_i & out_valid_q;
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = ~out_valid_q;
  assign wr_acc    = wr_en_i & (~full_o | pop);
  assign mem_empty = (count_q == CW'(out_valid_q));
  assign load_out  = ~out_valid_q | pop;
  assign mem_rd    = load_out & ~mem_empty;
  assign bypass    = load_out & mem_empty & wr_acc;
  assign mem_wr    = wr_acc & ~bypass;
  assign count_d   = count_q + CW'(wr_acc) - CW'(pop);
  assign rd_data_o = out_data_q;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, occupancy and the registered output stage
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (mem_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (mem_rd) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        out_data_q  <= mem[rd_ptr_q];
        out_valid_q <= 1'b1;
      end else if (bypass) begin
        out_data_q  <= wr_data_i;
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mixed_pixel_packer.sv
// Packs 16-bit mixed pixels four at a time into 64-bit words, buffers them in a
// FIFO and streams them out as AXI-Stream with SOF in tuser and burst/frame end
// in tlast. Flags dropped words with a sticky overflow bit.
module mixed_pixel_packer
  import pixel_stream_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_frame_start,
  input  logic [PIX_W-1:0]  i_pixel_data,
  input  logic              i_pixel_valid,
  output logic [AXIS_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              o_overflow,
  output logic              o_frame_done
);

  localparam int TOTAL_PX = H_ACTIVE * V_ACTIVE;
  localparam int WORDS    = TOTAL_PX / PIX_PER_WORD;
  localparam int PXC_W    = $clog2(TOTAL_PX + 1);
  localparam int WC_W     = $clog2(WORDS + 1);
  localparam int BC_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PACK_W   = PIX_W * (PIX_PER_WORD - 1);

  if ((TOTAL_PX % PIX_PER_WORD) != 0) begin : g_bad_geometry
    $error("mixed_pixel_packer: H_ACTIVE*V_ACTIVE must be a multiple of 4");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 * BURST_LEN) begin : g_bad_depth
    $error("mixed_pixel_packer: FIFO_DEPTH must be a power of 2 and >= 2*BURST_LEN");
  end

  // Input side state
  pack_state_e      state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [PACK_W-1:0] pack_q, pack_d;
  logic [PXC_W-1:0] px_cnt_q, px_cnt_d;
  logic [BC_W-1:0]  beat_q, beat_d;
  logic             sof_pend_q, sof_pend_d;
  logic             wr_en_q, wr_en_d;
  fifo_entry_t      wr_entry_q, wr_entry_d;

  // Output side state
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic [WC_W-1:0]  out_idx_q, out_idx_d;

  // Effective counters after a possible frame restart in this cycle
  logic [1:0]       slot_eff;
  logic [PXC_W-1:0] px_eff;
  logic [BC_W-1:0]  beat_eff;
  logic             sof_eff;
  logic             accept;
  logic             last_px;
  logic             tlast_tag;

  fifo_entry_t      fifo_out;
  logic             fifo_full;
  logic             fifo_empty;
  logic             handshake;
  logic [WC_W-1:0]  idx_eff;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n_i   (rst),
    .wr_en_i   (wr_en_q),
    .wr_data_i (wr_entry_q),
    .rd_en_i   (m_tready),
    .rd_data_o (fifo_out),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign m_tvalid     = ~fifo_empty;
  assign m_tdata      = fifo_out.data;
  assign m_tlast      = fifo_out.tlast;
  assign m_tuser      = fifo_out.tuser;
  assign o_overflow   = overflow_q;
  assign o_frame_done = done_q;
  assign handshake    = m_tvalid & m_tready;

  // Frame FSM, pixel packing and word tagging
  always_comb begin
    state_d    = state_q;
    pack_d     = pack_q;
    wr_en_d    = 1'b0;
    wr_entry_d = wr_entry_q;
    tlast_tag  = 1'b0;

    slot_eff = slot_q;
    px_eff   = px_cnt_q;
    beat_eff = beat_q;
    sof_eff  = sof_pend_q;
    if (i_frame_start) begin
      slot_eff = '0;
      px_eff   = '0;
      beat_eff = '0;
      sof_eff  = 1'b1;
      pack_d   = '0;
      state_d  = ACTIVE;
    end

    slot_d     = slot_eff;
    px_cnt_d   = px_eff;
    beat_d     = beat_eff;
    sof_pend_d = sof_eff;

    accept  = i_pixel_valid & (i_frame_start | (state_q == ACTIVE));
    last_px = (px_eff == PXC_W'(TOTAL_PX - 1));

    if (accept) begin
      px_cnt_d = px_eff + 1'b1;
      if (slot_eff == 2'd3) begin
        tlast_tag        = (beat_eff == BC_W'(BURST_LEN - 1)) | last_px;
        wr_en_d          = 1'b1;
        wr_entry_d.data  = {i_pixel_data, pack_d};
        wr_entry_d.tuser = sof_eff;
        wr_entry_d.tlast = tlast_tag;
        beat_d           = tlast_tag ? '0 : beat_eff + 1'b1;
        sof_pend_d       = 1'b0;
        slot_d           = '0;
      end else begin
        pack_d[int'(slot_eff) * PIX_W +: PIX_W] = i_pixel_data;
        slot_d = slot_eff + 1'b1;
      end
      if (last_px) begin
        state_d = WAIT_SOF;
      end
    end
  end

  // Output word position tracking, frame-done pulse and sticky overflow
  always_comb begin
    idx_eff    = fifo_out.tuser ? '0 : out_idx_q;
    out_idx_d  = handshake ? idx_eff + 1'b1 : out_idx_q;
    done_d     = handshake & fifo_out.tlast & (idx_eff == WC_W'(WORDS - 1));
    overflow_d = overflow_q | (wr_en_q & fifo_full & ~(m_tready & ~fifo_empty));
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= WAIT_SOF;
      slot_q     <= '0;
      pack_q     <= '0;
      px_cnt_q   <= '0;
      beat_q     <= '0;
      sof_pend_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_entry_q <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      pack_q     <= pack_d;
      px_cnt_q   <= px_cnt_d;
      beat_q     <= beat_d;
      sof_pend_q <= sof_pend_d;
      wr_en_q    <= wr_en_d;
      wr_entry_q <= wr_entry_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      out_idx_q  <= out_idx_d;
    end
  end

endmodule
